sram_blit_master: RTL and testbench
===================================

Name: sram_blit_master

Overview:
- Avalon-MM master (initiator) that drives the framebuffer SRAM slave port, the mirror of the SRAM multiplexer's slave side.
- Performs two rectangle operations on the 640x480, 16-bit-per-pixel framebuffer: solid fill, and copy from a source rectangle.
- Sits between the game/CPU control logic and the SRAM multiplexer. Offloads per-pixel writes so the VGA read slot is never starved.

Parameters:
- SCREEN_W, 640, pixels per row; pixel address = y*SCREEN_W + x.
- SCREEN_H, 480, rows.
- HOLD_CYCLES, 2, CLK2 cycles each read/write command is held stable. Must be >=2 so the command spans one slave service slot.
- READ_LATENCY, 4, CLK2 cycles from read-command assertion to AVL_READDATA being valid.

Ports:
- CLK2 in 1: clock.
- RESET in 1: synchronous, active-high.
- START in 1: one-cycle pulse; sampled only in IDLE.
- MODE in 1: 0 = fill, 1 = copy.
- DST_X in 10, DST_Y in 10: destination top-left corner.
- SRC_X in 10, SRC_Y in 10: source top-left corner (copy only).
- RECT_W in 10, RECT_H in 10: rectangle size in pixels.
- COLOR in 16: fill value.
- BUSY out 1: high from the cycle after START is accepted until DONE.
- DONE out 1: one-cycle pulse on completion.
- AVL_READ out 1, AVL_WRITE out 1: Avalon command strobes.
- AVL_ADDR out 20: Avalon address.
- AVL_WRITEDATA out 32: Avalon write data; {16'b0, pixel}.
- AVL_READDATA in 32: Avalon read data; bits [15:0] used.

Behaviour:
- Reset: state=IDLE; BUSY=0, DONE=0, AVL_READ=0, AVL_WRITE=0, AVL_ADDR=0, AVL_WRITEDATA=0. All counters are cleared.
- Reset mid-operation aborts immediately. No DONE is issued, and strobes are low on the next edge.
- Latching on START in IDLE: all inputs are latched; inputs may change afterwards without effect.
- Clipping in SETUP:
  - effW = min(RECT_W, SCREEN_W-DST_X), or 0 if DST_X>=SCREEN_W.
  - effH is computed the same way from DST_Y and SCREEN_H.
  - Copy mode additionally clips effW/effH against SRC_X/SRC_Y.
  - If effW==0 or effH==0: go to FINISH with no bus traffic.
- States: IDLE -> SETUP -> (MODE ? RD : WR). The flow is:
  - RD -> RD_WAIT -> WR.
  - WR -> ADV.
  - ADV -> RD / WR / FINISH.
  - FINISH -> IDLE.
- SETUP (1 cycle): compute row base dst_row = DST_Y*SCREEN_W + DST_X and src_row likewise. These are the only multiplies; everything after is incremental.
- RD:
  - AVL_READ=1, AVL_ADDR=src_row+col, held HOLD_CYCLES cycles, then AVL_READ=0.
  - RD_WAIT continues until READ_LATENCY cycles after RD entry.
  - Capture pix <= AVL_READDATA[15:0] on that edge.
- WR:
  - AVL_WRITE=1, AVL_ADDR=dst_row+col.
  - AVL_WRITEDATA={16'b0, MODE?pix:COLOR}.
  - Held HOLD_CYCLES cycles.
  - AVL_READ and AVL_WRITE are never high together.
- ADV (1 cycle, strobes low):
  - col++. When col==effW-1: col=0, row++, dst_row+=SCREEN_W, src_row+=SCREEN_W.
  - When row==effH-1 and col==effW-1: go to FINISH.
- FINISH: DONE=1 for one cycle; BUSY drops in the same cycle; return to IDLE.
- Order is raster, row-major, left-to-right, top-to-bottom.
- Copy with overlapping rectangles is processed forward only:
  - Result is correct when dst address <= src address.
  - Otherwise the source is read after it has been overwritten; this is a known limitation, not an error.
- Throughput:
  - Fill: HOLD_CYCLES+1 cycles/pixel.
  - Copy: READ_LATENCY+HOLD_CYCLES+1 cycles/pixel.
- START while BUSY is ignored.

Test Plan:
- Fill DST=(10,20), W=3, H=2, COLOR=16'hF800 -> writes to addrs 12810, 12811, 12812, 13450, 13451, 13452. Data 32'h0000F800, each held 2 cycles. DONE pulse after the 6th write; total 6 writes.
- Fill W=0 or DST_X=700 -> no AVL_READ/AVL_WRITE; DONE one cycle after SETUP.
- Clip: DST=(638,479), W=5, H=5 -> exactly 2 writes (addrs 307198, 307199).
- Copy SRC=(0,0), DST=(100,0), W=2, H=1, with a slave model returning data equal to the address -> reads 0 and 1, then writes 100←0x0000 and 101←0x0001. Read-to-capture spacing is exactly 4 cycles.
- Assert RESET during the 3rd write of a 4x4 fill -> strobes low next cycle, BUSY=0, no DONE. A new START then executes normally from pixel 0.
- START pulsed while BUSY with different COLOR -> ignored; all writes carry the original COLOR.

Source files
------------

// File: rtl/sram_blit_master.sv
// Avalon-MM blit master: solid fill or rectangle copy on a 640x480x16bpp SRAM framebuffer.
// Pixels are processed in raster order; each command is held for HOLD_CYCLES cycles.
module sram_blit_master #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int HOLD_CYCLES  = 2,
    parameter int READ_LATENCY = 4
) (
    input  logic        CLK2,
    input  logic        RESET,
    input  logic        START,
    input  logic        MODE,
    input  logic [9:0]  DST_X,
    input  logic [9:0]  DST_Y,
    input  logic [9:0]  SRC_X,
    input  logic [9:0]  SRC_Y,
    input  logic [9:0]  RECT_W,
    input  logic [9:0]  RECT_H,
    input  logic [15:0] COLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        AVL_READ,
    output logic        AVL_WRITE,
    output logic [19:0] AVL_ADDR,
    output logic [31:0] AVL_WRITEDATA,
    input  logic [31:0] AVL_READDATA
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RD, S_RD_WAIT, S_WR, S_ADV, S_FINISH
    } state_t;

    localparam logic [10:0] LIM_W     = 11'(SCREEN_W);
    localparam logic [10:0] LIM_H     = 11'(SCREEN_H);
    localparam logic [19:0] ROW_STEP  = 20'(SCREEN_W);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0]  LAT_LAST  = 8'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [9:0]  dst_x_q, dst_x_d, dst_y_q, dst_y_d;
    logic [9:0]  src_x_q, src_x_d, src_y_q, src_y_d;
    logic [9:0]  rect_w_q, rect_w_d, rect_h_q, rect_h_d;
    logic [15:0] color_q, color_d;
    logic [9:0]  eff_w_q, eff_w_d, eff_h_q, eff_h_d;
    logic [9:0]  col_q, col_d, row_q, row_d;
    logic [19:0] dst_row_q, dst_row_d, src_row_q, src_row_d;
    logic [15:0] pix_q, pix_d;
    logic [7:0]  timer_q, timer_d;
    logic [9:0]  eff_w_c, eff_h_c, src_w_c, src_h_c;
    logic        unused_readdata;

    // Length of a span starting at pos that still fits inside [0, lim).
    function automatic logic [9:0] clip_len(input logic [9:0] pos, input logic [9:0] size,
                                            input logic [10:0] lim);
        logic [10:0] room;
        room = lim - {1'b0, pos};
        if ({1'b0, pos} >= lim) return 10'd0;
        if ({1'b0, size} < room) return size;
        return room[9:0];
    endfunction

    always_comb begin
        eff_w_c = clip_len(dst_x_q, rect_w_q, LIM_W);
        eff_h_c = clip_len(dst_y_q, rect_h_q, LIM_H);
        src_w_c = clip_len(src_x_q, rect_w_q, LIM_W);
        src_h_c = clip_len(src_y_q, rect_h_q, LIM_H);
        if (mode_q && src_w_c < eff_w_c) eff_w_c = src_w_c;
        if (mode_q && src_h_c < eff_h_c) eff_h_c = src_h_c;
    end

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            dst_x_q   <= '0;
            dst_y_q   <= '0;
            src_x_q   <= '0;
            src_y_q   <= '0;
            rect_w_q  <= '0;
            rect_h_q  <= '0;
            color_q   <= '0;
            eff_w_q   <= '0;
            eff_h_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            dst_row_q <= '0;
            src_row_q <= '0;
            pix_q     <= '0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            dst_x_q   <= dst_x_d;
            dst_y_q   <= dst_y_d;
            src_x_q   <= src_x_d;
            src_y_q   <= src_y_d;
            rect_w_q  <= rect_w_d;
            rect_h_q  <= rect_h_d;
            color_q   <= color_d;
            eff_w_q   <= eff_w_d;
            eff_h_q   <= eff_h_d;
            col_q     <= col_d;
            row_q     <= row_d;
            dst_row_q <= dst_row_d;
            src_row_q <= src_row_d;
            pix_q     <= pix_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        dst_x_d   = dst_x_q;
        dst_y_d   = dst_y_q;
        src_x_d   = src_x_q;
        src_y_d   = src_y_q;
        rect_w_d  = rect_w_q;
        rect_h_d  = rect_h_q;
        color_d   = color_q;
        eff_w_d   = eff_w_q;
        eff_h_d   = eff_h_q;
        col_d     = col_q;
        row_d     = row_q;
        dst_row_d = dst_row_q;
        src_row_d = src_row_q;
        pix_d     = pix_q;
        timer_d   = timer_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mode_d   = MODE;
                    dst_x_d  = DST_X;
                    dst_y_d  = DST_Y;
                    src_x_d  = SRC_X;
                    src_y_d  = SRC_Y;
                    rect_w_d = RECT_W;
                    rect_h_d = RECT_H;
                    color_d  = COLOR;
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                eff_w_d   = eff_w_c;
                eff_h_d   = eff_h_c;
                dst_row_d = {10'd0, dst_y_q} * ROW_STEP + {10'd0, dst_x_q};
                src_row_d = {10'd0, src_y_q} * ROW_STEP + {10'd0, src_x_q};
                col_d     = '0;
                row_d     = '0;
                timer_d   = '0;
                if (eff_w_c == 10'd0 || eff_h_c == 10'd0) state_d = S_FINISH;
                else state_d = mode_q ? S_RD : S_WR;
            end
            // The timer keeps running from RD into RD_WAIT so capture lands READ_LATENCY after RD entry.
            S_RD: begin
                timer_d = timer_q + 8'd1;
                if (timer_q == HOLD_LAST) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (timer_q == LAT_LAST) begin
                    pix_d   = AVL_READDATA[15:0];
                    timer_d = '0;
                    state_d = S_WR;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_WR: begin
                if (timer_q == HOLD_LAST) begin
                    timer_d = '0;
                    state_d = S_ADV;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_ADV: begin
                state_d = mode_q ? S_RD : S_WR;
                if (col_q == eff_w_q - 10'd1) begin
                    col_d = '0;
                    if (row_q == eff_h_q - 10'd1) begin
                        state_d = S_FINISH;
                    end else begin
                        row_d     = row_q + 10'd1;
                        dst_row_d = dst_row_q + ROW_STEP;
                        src_row_d = src_row_q + ROW_STEP;
                    end
                end else begin
                    col_d = col_q + 10'd1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign BUSY      = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign DONE      = (state_q == S_FINISH);
    assign AVL_READ  = (state_q == S_RD);
    assign AVL_WRITE = (state_q == S_WR);
    assign AVL_ADDR  = (state_q == S_RD) ? src_row_q + {10'd0, col_q} :
                       (state_q == S_WR) ? dst_row_q + {10'd0, col_q} : 20'd0;
    assign AVL_WRITEDATA = (state_q == S_WR) ? {16'd0, (mode_q ? pix_q : color_q)} : 32'd0;

    assign unused_readdata = ^AVL_READDATA[31:16];

endmodule

// File: tb/tb_sram_blit_master.sv
// Randomized and directed bench for sram_blit_master: bus monitor, latency-exact read slave,
// and a per-rectangle reference list of expected reads/writes.
module tb_sram_blit_master;

    logic        CLK2 = 1'b0;
    logic        RESET, START, MODE;
    logic [9:0]  DST_X, DST_Y, SRC_X, SRC_Y, RECT_W, RECT_H;
    logic [15:0] COLOR;
    logic        BUSY, DONE, AVL_READ, AVL_WRITE;
    logic [19:0] AVL_ADDR;
    logic [31:0] AVL_WRITEDATA, AVL_READDATA;

    sram_blit_master dut (
        .CLK2(CLK2), .RESET(RESET), .START(START), .MODE(MODE),
        .DST_X(DST_X), .DST_Y(DST_Y), .SRC_X(SRC_X), .SRC_Y(SRC_Y),
        .RECT_W(RECT_W), .RECT_H(RECT_H), .COLOR(COLOR),
        .BUSY(BUSY), .DONE(DONE), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
        .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
    );

    always #5 CLK2 = ~CLK2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and read slave (data valid only in the cycle before the capture edge)
    int          cyc = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
    int          done_cnt = 0, done_cyc = 0;
    logic        prev_wr = 1'b0, prev_rd = 1'b0;
    int          wr_len = 0, rd_len = 0, rd_age = 0;
    logic [19:0] rd_addr_hold = '0;

    always @(posedge CLK2) cyc <= cyc + 1;

    assign AVL_READDATA = (rd_age == 4) ? {16'hBEEF, rd_addr_hold[15:0]}
                                        : {16'hBEEF, ~rd_addr_hold[15:0]};

    always @(negedge CLK2) begin
        if (RESET) begin
            prev_wr = 1'b0; prev_rd = 1'b0; wr_len = 0; rd_len = 0; rd_age = 0;
        end else begin
            if (AVL_READ || AVL_WRITE) check_eq("rw_excl", 32'(AVL_READ & AVL_WRITE), 32'd0);
            if (AVL_WRITE) begin
                if (!prev_wr) begin
                    wr_addr_q.push_back(32'(AVL_ADDR));
                    wr_data_q.push_back(AVL_WRITEDATA);
                    wr_len = 1;
                end else wr_len++;
            end else if (prev_wr) check_eq("wr_hold", wr_len, 2);
            if (AVL_READ) begin
                if (!prev_rd) begin
                    rd_addr_q.push_back(32'(AVL_ADDR));
                    rd_addr_hold = AVL_ADDR;
                    rd_len = 1;
                    rd_age = 1;
                end else begin
                    rd_len++;
                    rd_age++;
                end
            end else begin
                if (prev_rd) check_eq("rd_hold", rd_len, 2);
                if (rd_age > 0) rd_age++;
            end
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
                check_eq("busy_at_done", 32'(BUSY), 32'd0);
            end
            prev_wr = AVL_WRITE;
            prev_rd = AVL_READ;
        end
    end

    function automatic int clip(input int pos, input int size, input int lim);
        if (pos >= lim) return 0;
        return (size < lim - pos) ? size : lim - pos;
    endfunction

    function automatic logic [9:0] rnd_coord(input int lim);
        if ($urandom_range(0, 3) == 0) return 10'(lim - 4 + $urandom_range(0, 8));
        return 10'($urandom_range(0, lim - 1));
    endfunction

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        done_cnt = 0;
    endtask

    task automatic scramble_inputs();
        MODE = 1'($urandom); DST_X = 10'($urandom); DST_Y = 10'($urandom);
        SRC_X = 10'($urandom); SRC_Y = 10'($urandom); RECT_W = 10'($urandom);
        RECT_H = 10'($urandom); COLOR = 16'($urandom);
    endtask

    task automatic run_op(input string tag, input logic m, input int dx, input int dy,
                          input int sx, input int sy, input int w, input int h,
                          input logic [15:0] col, input bit restart_busy);
        int ew, eh, npx, start_cyc, nw, nr;
        logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
        ew = clip(dx, w, 640);
        eh = clip(dy, h, 480);
        if (m) begin
            if (clip(sx, w, 640) < ew) ew = clip(sx, w, 640);
            if (clip(sy, h, 480) < eh) eh = clip(sy, h, 480);
        end
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++) begin
                exp_wa.push_back(32'((dy + r) * 640 + dx + c));
                exp_ra.push_back(32'((sy + r) * 640 + sx + c));
                exp_wd.push_back(m ? 32'(((sy + r) * 640 + sx + c) & 16'hFFFF) : {16'd0, col});
            end
        npx = ew * eh;
        clear_mon();
        @(negedge CLK2);
        MODE = m; DST_X = 10'(dx); DST_Y = 10'(dy); SRC_X = 10'(sx); SRC_Y = 10'(sy);
        RECT_W = 10'(w); RECT_H = 10'(h); COLOR = col; START = 1'b1;
        start_cyc = cyc;
        @(negedge CLK2);
        START = 1'b0;
        scramble_inputs();
        check_eq({tag, "_busy"}, 32'(BUSY), 32'd1);
        if (restart_busy) begin
            repeat (3) @(negedge CLK2);
            COLOR = ~col;
            START = 1'b1;
            @(negedge CLK2);
            START = 1'b0;
        end
        for (int i = 0; i < 4000 && done_cnt == 0; i++) @(negedge CLK2);
        check_eq({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (4) @(negedge CLK2);
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_latency"}, done_cyc - start_cyc, 2 + npx * (m ? 7 : 3));
        nw = wr_addr_q.size();
        nr = rd_addr_q.size();
        check_eq({tag, "_nwrites"}, nw, npx);
        check_eq({tag, "_nreads"}, nr, m ? npx : 0);
        for (int i = 0; i < npx && i < nw; i++) begin
            check_eq({tag, "_waddr"}, wr_addr_q[i], exp_wa[i]);
            check_eq({tag, "_wdata"}, wr_data_q[i], exp_wd[i]);
        end
        for (int i = 0; m && i < npx && i < nr; i++)
            check_eq({tag, "_raddr"}, rd_addr_q[i], exp_ra[i]);
        $display("op %s mode=%0d dst=(%0d,%0d) src=(%0d,%0d) size=%0dx%0d eff=%0dx%0d writes=%0d reads=%0d",
                 tag, m, dx, dy, sx, sy, w, h, ew, eh, nw, nr);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0;
        MODE = 1'b0; DST_X = '0; DST_Y = '0; SRC_X = '0; SRC_Y = '0;
        RECT_W = '0; RECT_H = '0; COLOR = '0;
        repeat (3) @(negedge CLK2);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_read", 32'(AVL_READ), 32'd0);
        check_eq("rst_write", 32'(AVL_WRITE), 32'd0);
        check_eq("rst_addr", 32'(AVL_ADDR), 32'd0);
        check_eq("rst_wdata", AVL_WRITEDATA, 32'd0);
        RESET = 1'b0;
        $display("reset released");

        run_op("fill_basic", 1'b0, 10, 20, 0, 0, 3, 2, 16'hF800, 1'b0);
        run_op("fill_w0",    1'b0, 5, 5, 0, 0, 0, 4, 16'h1111, 1'b0);
        run_op("fill_x700",  1'b0, 700, 5, 0, 0, 4, 4, 16'h2222, 1'b0);
        run_op("fill_clip",  1'b0, 638, 479, 0, 0, 5, 5, 16'h3333, 1'b0);
        run_op("copy_basic", 1'b1, 100, 0, 0, 0, 2, 1, 16'h4444, 1'b0);

        // Abort a 4x4 fill during its third write
        clear_mon();
        @(negedge CLK2);
        MODE = 1'b0; DST_X = 10'd5; DST_Y = 10'd5; RECT_W = 10'd4; RECT_H = 10'd4;
        COLOR = 16'h1234; START = 1'b1;
        @(negedge CLK2);
        START = 1'b0;
        for (int i = 0; i < 200 && wr_addr_q.size() < 3; i++) begin
            @(negedge CLK2);
            #1;
        end
        check_eq("abort_reached_w3", wr_addr_q.size(), 3);
        RESET = 1'b1;
        @(negedge CLK2);
        check_eq("abort_write", 32'(AVL_WRITE), 32'd0);
        check_eq("abort_read", 32'(AVL_READ), 32'd0);
        check_eq("abort_busy", 32'(BUSY), 32'd0);
        check_eq("abort_done", 32'(DONE), 32'd0);
        #1 RESET = 1'b0;
        repeat (10) @(negedge CLK2);
        check_eq("abort_no_done", done_cnt, 0);
        $display("op abort writes_before_reset=%0d", wr_addr_q.size());
        run_op("after_abort", 1'b0, 5, 5, 0, 0, 4, 4, 16'h1234, 1'b0);

        run_op("start_busy", 1'b0, 1, 2, 0, 0, 4, 4, 16'h07E0, 1'b1);

        for (int k = 0; k < 20; k++) begin
            logic mm;
            mm = 1'($urandom);
            run_op($sformatf("rand%0d", k), mm, int'(rnd_coord(640)), int'(rnd_coord(480)),
                   int'(rnd_coord(640)), int'(rnd_coord(480)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   16'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
